// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction
// memory and buffers {pc, instruction, misaligned} in a small FIFO that is
// drained by decode through a valid/ready handshake. A redirect flushes the
// queue and restarts fetching at the (word-aligned) target.
module instruction_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  out_misaligned
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  // Queue storage (no reset needed: contents are only visible when count != 0)
  logic [ADDR_WIDTH-1:0] pc_mem_q    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem_q [FIFO_DEPTH];
  logic                  mis_mem_q   [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                  pending_mis_q, pending_mis_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic deq_s;
  logic push_s;
  logic full_s;

  assign imem_addr = fetch_pc_q;
  assign out_valid = (count_q != CNT_W'(0));
  assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));

  // Handshake decode: a slot frees up in the same cycle the head is consumed,
  // so a full queue can still accept a new fetch when decode is draining it.
  always_comb begin
    deq_s  = out_valid && out_ready;
    push_s = 1'b0;
    if (redirect_valid) begin
      push_s = 1'b0;
    end else begin
      push_s = !full_s || deq_s;
    end
  end

  // Head presentation: empty queue shows a NOP at pc 0 so decode sees benign values
  always_comb begin
    out_instr      = NOP_INSTR;
    out_pc         = '0;
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_instr      = instr_mem_q[rd_ptr_q];
      out_pc         = pc_mem_q[rd_ptr_q];
      out_misaligned = mis_mem_q[rd_ptr_q];
    end else begin
      out_instr      = NOP_INSTR;
      out_pc         = '0;
      out_misaligned = 1'b0;
    end
  end

  // Next-state for PC, pointers and occupancy; a redirect overrides push and deq
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pending_mis_d = pending_mis_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect_valid) begin
      fetch_pc_d    = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      pending_mis_d = |redirect_pc[1:0];
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      count_d       = '0;
    end else begin
      if (push_s) begin
        fetch_pc_d    = fetch_pc_q + ADDR_WIDTH'(4);
        pending_mis_d = 1'b0;
        wr_ptr_d      = wr_ptr_q + PTR_W'(1);
      end else begin
        fetch_pc_d    = fetch_pc_q;
        pending_mis_d = pending_mis_q;
        wr_ptr_d      = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      pending_mis_q <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pending_mis_q <= pending_mis_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Tail write of the fetched entry
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_instr;
      mis_mem_q[wr_ptr_q]   <= pending_mis_q;
    end
  end

endmodule
